// File: rtl/cmd_bus_pkg.sv
// Shared command-bus definitions: address fields, register indices, pin modes
// and the pin-controller state encoding.
package cmd_bus_pkg;

  localparam int SLOT_H = 15;
  localparam int SLOT_L = 8;
  localparam int IDX_H  = 7;
  localparam int IDX_L  = 0;

  localparam logic [7:0] REG_CTRL    = 8'h00;
  localparam logic [7:0] REG_HIGH    = 8'h01;
  localparam logic [7:0] REG_LOW     = 8'h02;
  localparam logic [7:0] REG_DIV     = 8'h03;
  localparam logic [7:0] REG_SAMPLES = 8'h04;
  localparam logic [7:0] REG_COUNT   = 8'h05;

  localparam logic [2:0] MODE_IDLE = 3'd0;
  localparam logic [2:0] MODE_LOW  = 3'd1;
  localparam logic [2:0] MODE_HIGH = 3'd2;
  localparam logic [2:0] MODE_SQ   = 3'd3;
  localparam logic [2:0] MODE_REC  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_SQ_HI = 3'd3,
    ST_SQ_LO = 3'd4,
    ST_REC   = 3'd5
  } pin_state_e;

  // A programmed period of zero behaves as a single cycle.
  function automatic logic [31:0] clamp_period(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/pin_sampler.sv
// Record-mode capture: divides the clock, shifts pin_in into a sample
// register and keeps a saturating count of samples taken.
module pin_sampler
  import cmd_bus_pkg::*;
#(
  parameter int SAMPLE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                enable,
  input  logic [31:0]         div,
  input  logic                pin_in,
  output logic [SAMPLE_W-1:0] samples,
  output logic [SAMPLE_W-1:0] count
);

  logic [31:0]         div_cnt_r;
  logic [SAMPLE_W-1:0] samples_r;
  logic [SAMPLE_W-1:0] count_r;

  // Divider, shift register and saturating sample counter.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_cnt_r <= 32'd0;
      samples_r <= '0;
      count_r   <= '0;
    end else if (enable) begin
      if (div_cnt_r >= div) begin
        div_cnt_r <= 32'd0;
        samples_r <= {samples_r[SAMPLE_W-2:0], pin_in};
        if (count_r != {SAMPLE_W{1'b1}}) begin
          count_r <= count_r + SAMPLE_W'(1);
        end else begin
          count_r <= count_r;
        end
      end else begin
        div_cnt_r <= div_cnt_r + 32'd1;
      end
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

  assign samples = samples_r;
  assign count   = count_r;

endmodule

// File: rtl/pin_controller.sv
// Per-pin responder on the command bus: register decode, waveform FSM and
// read-back of status and recorded samples.
module pin_controller
  import cmd_bus_pkg::*;
#(
  parameter logic [7:0] POSITION = 8'd0,
  parameter int         SAMPLE_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd_bus_addr,
  input  logic [31:0] cmd_bus_data,
  input  logic        cmd_bus_en,
  input  logic        cmd_bus_wr,
  input  logic        cmd_bus_rd,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        pin_in,
  output logic        pin_out,
  output logic        pin_oe
);

  logic                hit_s;
  logic [7:0]          idx_s;
  logic                wr_s;
  logic                rd_s;
  logic                ctrl_wr_s;
  logic [31:0]         rd_mux_s;
  logic [SAMPLE_W-1:0] samples_s;
  logic [SAMPLE_W-1:0] count_s;

  logic [2:0]  ctrl_r;
  logic [31:0] high_cfg_r;
  logic [31:0] low_cfg_r;
  logic [31:0] div_cfg_r;
  logic [31:0] high_lim_r;
  logic [31:0] low_lim_r;
  logic [31:0] div_lim_r;
  logic [31:0] phase_cnt_r;
  pin_state_e  state_r;
  logic        pin_out_r;
  logic        pin_oe_r;
  logic [31:0] rd_data_r;
  logic        rd_valid_r;

  assign hit_s     = cmd_bus_en & (cmd_bus_addr[SLOT_H:SLOT_L] == POSITION);
  assign idx_s     = cmd_bus_addr[IDX_H:IDX_L];
  assign wr_s      = hit_s & cmd_bus_wr;
  assign rd_s      = hit_s & cmd_bus_rd & ~cmd_bus_wr;
  assign ctrl_wr_s = wr_s & (idx_s == REG_CTRL);

  // Host-visible registers; period/divider values are committed on CTRL writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r     <= 3'd0;
      high_cfg_r <= 32'd0;
      low_cfg_r  <= 32'd0;
      div_cfg_r  <= 32'd0;
      high_lim_r <= 32'd0;
      low_lim_r  <= 32'd0;
      div_lim_r  <= 32'd0;
    end else begin
      if (wr_s) begin
        case (idx_s)
          REG_CTRL: ctrl_r     <= cmd_bus_data[2:0];
          REG_HIGH: high_cfg_r <= cmd_bus_data;
          REG_LOW:  low_cfg_r  <= cmd_bus_data;
          REG_DIV:  div_cfg_r  <= cmd_bus_data;
          default:  ctrl_r     <= ctrl_r;
        endcase
      end
      if (ctrl_wr_s) begin
        high_lim_r <= clamp_period(high_cfg_r);
        low_lim_r  <= clamp_period(low_cfg_r);
        div_lim_r  <= div_cfg_r;
      end
    end
  end

  // Waveform FSM; pin drive is registered from the state one cycle behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      phase_cnt_r <= 32'd0;
      pin_out_r   <= 1'b0;
      pin_oe_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_LOW:   begin pin_out_r <= 1'b0; pin_oe_r <= 1'b1; end
        ST_HIGH:  begin pin_out_r <= 1'b1; pin_oe_r <= 1'b1; end
        ST_SQ_HI: begin pin_out_r <= 1'b1; pin_oe_r <= 1'b1; end
        ST_SQ_LO: begin pin_out_r <= 1'b0; pin_oe_r <= 1'b1; end
        default:  begin pin_out_r <= 1'b0; pin_oe_r <= 1'b0; end
      endcase

      if (ctrl_wr_s) begin
        phase_cnt_r <= 32'd0;
        case (cmd_bus_data[2:0])
          MODE_LOW:  state_r <= ST_LOW;
          MODE_HIGH: state_r <= ST_HIGH;
          MODE_SQ:   state_r <= ST_SQ_HI;
          MODE_REC:  state_r <= ST_REC;
          default:   state_r <= ST_IDLE;
        endcase
      end else begin
        case (state_r)
          ST_SQ_HI: begin
            if (phase_cnt_r + 32'd1 >= high_lim_r) begin
              state_r     <= ST_SQ_LO;
              phase_cnt_r <= 32'd0;
            end else begin
              phase_cnt_r <= phase_cnt_r + 32'd1;
            end
          end
          ST_SQ_LO: begin
            if (phase_cnt_r + 32'd1 >= low_lim_r) begin
              state_r     <= ST_SQ_HI;
              phase_cnt_r <= 32'd0;
            end else begin
              phase_cnt_r <= phase_cnt_r + 32'd1;
            end
          end
          default: phase_cnt_r <= 32'd0;
        endcase
      end
    end
  end

  pin_sampler #(
    .SAMPLE_W (SAMPLE_W)
  ) u_sampler (
    .clk     (clk),
    .rst     (rst),
    .clear   (ctrl_wr_s),
    .enable  (state_r == ST_REC),
    .div     (div_lim_r),
    .pin_in  (pin_in),
    .samples (samples_s),
    .count   (count_s)
  );

  // Read-data selection by register index.
  always_comb begin
    rd_mux_s = 32'd0;
    case (idx_s)
      REG_CTRL:    rd_mux_s = {29'd0, ctrl_r};
      REG_HIGH:    rd_mux_s = high_cfg_r;
      REG_LOW:     rd_mux_s = low_cfg_r;
      REG_DIV:     rd_mux_s = div_cfg_r;
      REG_SAMPLES: rd_mux_s = 32'(samples_s);
      REG_COUNT:   rd_mux_s = 32'(count_s);
      default:     rd_mux_s = 32'd0;
    endcase
  end

  // One-cycle read response; data is zero otherwise so slots can be OR-combined.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r  <= 32'd0;
      rd_valid_r <= 1'b0;
    end else if (rd_s) begin
      rd_data_r  <= rd_mux_s;
      rd_valid_r <= 1'b1;
    end else begin
      rd_data_r  <= 32'd0;
      rd_valid_r <= 1'b0;
    end
  end

  assign pin_out  = pin_out_r;
  assign pin_oe   = pin_oe_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;

endmodule

// File: tb/tb_pin_controller.sv
// Directed bench for pin_controller at slot 3 with hand-computed expectations.
module tb_pin_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd_bus_addr;
  logic [31:0] cmd_bus_data;
  logic        cmd_bus_en;
  logic        cmd_bus_wr;
  logic        cmd_bus_rd;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        pin_in;
  logic        pin_out;
  logic        pin_oe;

  int n_vec = 0;
  int n_err = 0;

  pin_controller #(
    .POSITION (8'd3),
    .SAMPLE_W (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_bus_addr (cmd_bus_addr),
    .cmd_bus_data (cmd_bus_data),
    .cmd_bus_en   (cmd_bus_en),
    .cmd_bus_wr   (cmd_bus_wr),
    .cmd_bus_rd   (cmd_bus_rd),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .pin_in       (pin_in),
    .pin_out      (pin_out),
    .pin_oe       (pin_oe)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    cmd_bus_addr = a;
    cmd_bus_data = d;
    cmd_bus_en   = 1'b1;
    cmd_bus_wr   = 1'b1;
    step();
    cmd_bus_en   = 1'b0;
    cmd_bus_wr   = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a);
    cmd_bus_addr = a;
    cmd_bus_en   = 1'b1;
    cmd_bus_rd   = 1'b1;
    step();
    cmd_bus_en   = 1'b0;
    cmd_bus_rd   = 1'b0;
  endtask

  logic [9:0] sq_pat  = 10'b0011100111;
  logic [6:0] def_pat = 7'b1011111;
  logic [7:0] rec_pat = 8'b11110011;

  initial begin
    rst = 1'b1;
    cmd_bus_addr = 16'h0000;
    cmd_bus_data = 32'd0;
    cmd_bus_en = 1'b0;
    cmd_bus_wr = 1'b0;
    cmd_bus_rd = 1'b0;
    pin_in = 1'b0;
    repeat (3) step();
    check_val("reset_oe", 32'(pin_oe), 32'd0);
    check_val("reset_out", 32'(pin_out), 32'd0);
    check_val("reset_rd_data", rd_data, 32'd0);
    check_val("reset_rd_valid", 32'(rd_valid), 32'd0);
    rst = 1'b0;
    step();

    // Slot decode
    bus_write(16'h0200, 32'd2);
    step();
    check_val("wrong_slot_oe", 32'(pin_oe), 32'd0);
    bus_write(16'h0300, 32'd2);
    step();
    check_val("high_oe", 32'(pin_oe), 32'd1);
    check_val("high_out", 32'(pin_out), 32'd1);

    // Square wave 3 high / 2 low
    bus_write(16'h0301, 32'd3);
    bus_write(16'h0302, 32'd2);
    bus_write(16'h0300, 32'd3);
    for (int i = 0; i < 10; i++) begin
      step();
      check_val($sformatf("sq_out[%0d]", i), 32'(pin_out), 32'(sq_pat[i]));
    end
    check_val("sq_oe", 32'(pin_oe), 32'd1);

    // Zero periods toggle every cycle
    bus_write(16'h0301, 32'd0);
    bus_write(16'h0302, 32'd0);
    bus_write(16'h0300, 32'd3);
    for (int i = 0; i < 6; i++) begin
      step();
      check_val($sformatf("zero_out[%0d]", i), 32'(pin_out), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    // HIGH change mid-run is deferred
    bus_write(16'h0301, 32'd5);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val($sformatf("defer_out[%0d]", i), 32'(pin_out), (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    bus_write(16'h0300, 32'd3);
    for (int i = 0; i < 7; i++) begin
      step();
      check_val($sformatf("h5_out[%0d]", i), 32'(pin_out), 32'(def_pat[i]));
    end

    // Record: divider 1, pattern 1,0,1,1 held two cycles each
    bus_write(16'h0303, 32'd1);
    bus_write(16'h0300, 32'd4);
    for (int k = 0; k < 8; k++) begin
      pin_in = rec_pat[k];
      step();
    end
    check_val("rec_oe", 32'(pin_oe), 32'd0);
    bus_read(16'h0305);
    check_val("count_valid", 32'(rd_valid), 32'd1);
    check_val("count_data", rd_data, 32'd4);
    bus_read(16'h0304);
    check_val("samples_valid", 32'(rd_valid), 32'd1);
    check_val("samples_data", rd_data, 32'h0000000B);
    step();
    check_val("rd_valid_drop", 32'(rd_valid), 32'd0);
    check_val("rd_data_idle", rd_data, 32'd0);

    // Read edge cases
    bus_read(16'h0307);
    check_val("unmapped_valid", 32'(rd_valid), 32'd1);
    check_val("unmapped_data", rd_data, 32'd0);
    bus_read(16'h0207);
    check_val("other_slot_valid", 32'(rd_valid), 32'd0);
    cmd_bus_addr = 16'h0300;
    cmd_bus_data = 32'd1;
    cmd_bus_en = 1'b1;
    cmd_bus_wr = 1'b1;
    cmd_bus_rd = 1'b1;
    step();
    cmd_bus_en = 1'b0;
    cmd_bus_wr = 1'b0;
    cmd_bus_rd = 1'b0;
    check_val("rdwr_no_valid", 32'(rd_valid), 32'd0);
    step();
    check_val("rdwr_low_oe", 32'(pin_oe), 32'd1);
    check_val("rdwr_low_out", 32'(pin_out), 32'd0);
    bus_read(16'h0300);
    check_val("ctrl_readback", rd_data, 32'd1);

    // Reset mid-run in SQ_HI, coinciding with a read strobe
    bus_write(16'h0301, 32'd4);
    bus_write(16'h0300, 32'd3);
    step();
    check_val("pre_rst_out", 32'(pin_out), 32'd1);
    cmd_bus_addr = 16'h0301;
    cmd_bus_en = 1'b1;
    cmd_bus_rd = 1'b1;
    rst = 1'b1;
    step();
    cmd_bus_en = 1'b0;
    cmd_bus_rd = 1'b0;
    check_val("rst_oe", 32'(pin_oe), 32'd0);
    check_val("rst_out", 32'(pin_out), 32'd0);
    check_val("rst_rd_data", rd_data, 32'd0);
    check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
    rst = 1'b0;
    bus_read(16'h0301);
    check_val("post_rst_valid", 32'(rd_valid), 32'd1);
    check_val("post_rst_high", rd_data, 32'd0);
    step();
    check_val("post_rst_oe", 32'(pin_oe), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pin_controller.md
Name: pin_controller

Overview:
- Responder end of the command bus driven by the command scheduler. One instance per physical pin.
- Decodes bus writes addressed to its slot, captures register values, and drives its pin in one of several modes: tri-state, constant low, constant high, square wave, or record.
- Answers bus reads with status and recorded samples, so the host can read back pin activity.

Parameters:
- POSITION, 8'd0, bus slot; the block responds only when cmd_bus_addr[15:8] == POSITION.
- SAMPLE_W, 32, width of the record shift register and of the sample counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_bus_addr  in  16  [15:8] slot, [7:0] register index
- cmd_bus_data  in  32  write data
- cmd_bus_en  in  1  bus cycle valid
- cmd_bus_wr  in  1  write strobe, qualified by en
- cmd_bus_rd  in  1  read strobe, qualified by en
- rd_data  out  32  read data; 0 when not driving, so it can be OR-combined
- rd_valid  out  1  one-cycle read response
- pin_in  in  1  pin input, already synchronised upstream
- pin_out  out  1  pin drive value
- pin_oe  out  1  pin output enable

Behaviour:
- Clock and reset: one clock, clk. Reset (rst) is synchronous and active-high.
- Reset values:
  - Outputs: pin_out=0, pin_oe=0, rd_data=0, rd_valid=0.
  - Registers all 0; state IDLE.
- Address hit: hit = cmd_bus_en & (cmd_bus_addr[15:8]==POSITION).
- Writes (hit & wr): register updated on the same edge the strobe is sampled. The scheduler holds en/wr for exactly one cycle, so no back-pressure exists.
- Register map (index 0x00-0x05):
  - 0x00 CTRL: bits[2:0] mode. Writing CTRL commits the mode and restarts all counters.
  - 0x01 HIGH_CYCLES (32b)
  - 0x02 LOW_CYCLES (32b)
  - 0x03 SAMPLE_DIV (32b)
  - 0x04 SAMPLES, read-only shift register
  - 0x05 SAMPLE_COUNT, read-only
- Register access rules:
  - Writes to 0x01-0x03 take effect only at the next CTRL write. They do not disturb a running waveform.
  - Writes to 0x04, 0x05 and to unmapped indices are ignored.
- Reads (hit & rd & ~wr):
  - rd_valid=1 and rd_data=register value on the following cycle, for exactly one cycle.
  - Unmapped indices return 0 with rd_valid=1.
  - Simultaneous rd & wr: write wins; no read response.
- Modes and state machine (states IDLE, LOW, HIGH, SQ_HI, SQ_LO, REC), entered on a CTRL write:
  - 0 → IDLE: pin_oe=0.
  - 1 → LOW: oe=1, out=0.
  - 2 → HIGH: oe=1, out=1.
  - 3 → SQ_HI: oe=1, out=1.
  - 4 → REC: oe=0.
  - 5-7 → IDLE.
  - SQ_HI→SQ_LO when the high counter reaches the committed HIGH_CYCLES; SQ_LO→SQ_HI on LOW_CYCLES; repeats forever.
  - A HIGH_CYCLES or LOW_CYCLES value of 0 is treated as 1.
- Outputs are registered. A CTRL write sampled at edge N gives the new pin_out/pin_oe from edge N+1. In mode 3, pin_out is high for exactly HIGH_CYCLES cycles, then low for LOW_CYCLES cycles.
- REC mode:
  - Every SAMPLE_DIV+1 cycles, shift pin_in into SAMPLES at bit 0 (MSB dropped) and increment SAMPLE_COUNT.
  - SAMPLE_COUNT saturates at all-ones.
  - The first sample is taken SAMPLE_DIV+1 cycles after entry.
- Any CTRL write (including entering REC again) clears SAMPLES and SAMPLE_COUNT.
- A CTRL write mid-waveform aborts the current phase immediately; no glitch-free completion.
- Counters are 32-bit and never wrap within a phase, because they compare with ">=" against the committed limit.
- rst asserted mid-operation: everything returns to reset values on the next edge; pin_oe drops to 0.

Decomposition:
- Shared package (cmd_bus_pkg):
  - Register index constants: REG_CTRL, REG_HIGH, REG_LOW, REG_DIV, REG_SAMPLES, REG_COUNT.
  - Mode encodings: MODE_IDLE..MODE_REC.
  - Address field widths (SLOT_H/L, IDX_H/L).
- One natural sub-module: pin_sampler, covering the REC divider, shift register and saturating counter. The top level holds bus decode, registers and the waveform FSM.

Test Plan:
- Slot decode: POSITION=3; write CTRL=2 at addr 0x0200, then at 0x0300 → pin unchanged (oe=0) after the first write; after the second, oe=1 and out=1 from edge N+1.
- Square wave: write HIGH=3, LOW=2, then CTRL=3 → pin_out sequence 1,1,1,0,0,1,1,1,0,0… starting at edge N+1.
- Zero and deferred periods: HIGH=0, LOW=0, CTRL=3 → toggles every cycle. Writing HIGH=5 mid-run does not change the period until the next CTRL=3.
- Record: SAMPLE_DIV=1, CTRL=4, pin_in pattern 1,0,1,1 held 2 cycles each → after 8 cycles, read 0x05 returns 4 and read 0x04 returns 0xB, each with a one-cycle rd_valid.
- Read edge cases: read of 0x07 → rd_valid=1, rd_data=0. Simultaneous rd & wr to CTRL → no rd_valid, CTRL updated.
- Reset mid-run: assert rst during SQ_HI → next edge pin_oe=0, pin_out=0, rd_data=0. After release, a read of 0x01 returns 0.
